// File: rtl/counter_seq_ctrl.sv
// Job sequencer for an external up/down counter: load a start value,
// step toward a target, and report completion or cancellation.
module counter_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_start,
  input  logic [WIDTH-1:0] req_target,
  input  logic             req_dir,
  input  logic             pause,
  input  logic             abort,
  output logic             cnt_ld_en,
  output logic             cnt_updwn,
  output logic             cnt_en,
  output logic [WIDTH-1:0] cnt_datain,
  input  logic [WIDTH-1:0] cnt_dataout,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] steps
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] target_q;
  logic             dir_q;
  logic             hit;

  assign hit = (cnt_dataout == target_q);

  // Counter strobes stay combinational so pause/abort act in the same cycle.
  always_comb begin
    req_ready  = (state == S_IDLE);
    busy       = (state == S_LOAD) || (state == S_COUNT);
    done       = (state == S_DONE);
    cnt_ld_en  = (state == S_LOAD) && !abort;
    cnt_en     = (state == S_COUNT) && !hit && !pause && !abort;
    cnt_datain = start_q;
    cnt_updwn  = dir_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      start_q  <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
      aborted  <= 1'b0;
      steps    <= '0;
    end else begin
      aborted <= 1'b0;
      if (cnt_en)
        steps <= steps + 1'b1;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            start_q  <= req_start;
            target_q <= req_target;
            dir_q    <= req_dir;
            steps    <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= S_IDLE;
          end else begin
            state <= S_COUNT;
          end
        end
        S_COUNT: begin
          // Abort outranks the target match.
          if (abort) begin
            aborted <= 1'b1;
            state   <= S_IDLE;
          end else if (hit) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl with a behavioural counter
// and a job-level reference model.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_start = '0;
  logic [7:0] req_target = '0;
  logic       req_dir = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       cnt_ld_en;
  logic       cnt_updwn;
  logic       cnt_en;
  logic [7:0] cnt_datain;
  logic [7:0] cnt_dataout;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] steps;

  counter_seq_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_start  (req_start),
    .req_target (req_target),
    .req_dir    (req_dir),
    .pause      (pause),
    .abort      (abort),
    .cnt_ld_en  (cnt_ld_en),
    .cnt_updwn  (cnt_updwn),
    .cnt_en     (cnt_en),
    .cnt_datain (cnt_datain),
    .cnt_dataout(cnt_dataout),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .steps      (steps)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt_dataout <= '0;
    else if (cnt_ld_en) cnt_dataout <= cnt_datain;
    else if (cnt_en)    cnt_dataout <= cnt_updwn ? cnt_dataout + 8'd1
                                                 : cnt_dataout - 8'd1;
  end

  typedef struct {
    bit abrt;
    int steps;
    int lat;
    int acc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         pz[0:1023];
  logic [7:0] cur_start = '0;
  logic       cur_dir = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Job-level model: LOAD is cycle 1, COUNT from cycle 2; the returned
  // latency is the number of edges from accept to the pulse.
  function automatic void model(input logic [7:0] st, input logic [7:0] tg,
                                input logic d, input int ab_at,
                                output exp_t e);
    logic [7:0] rem;
    int t;
    rem = d ? tg - st : st - tg;
    e.abrt = 0;
    e.steps = 0;
    t = 1;
    while (t < 1000) begin
      if (t == ab_at) begin
        e.abrt = 1;
        break;
      end
      if (t >= 2) begin
        if (rem == 0) break;
        if (!pz[t]) begin
          rem = rem - 8'd1;
          e.steps++;
        end
      end
      t++;
    end
    e.lat = t;
    e.acc = 0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if ({req_ready, cnt_ld_en, cnt_en, cnt_updwn, cnt_datain, busy,
           done, aborted, steps} != {1'b1, 3'b000, 8'd0, 3'b000, 8'd0}) begin
        fails++;
        $display("FAIL reset_vals got rdy=%b ld=%b en=%b ud=%b din=%0d busy=%b done=%b ab=%b steps=%0d",
                 req_ready, cnt_ld_en, cnt_en, cnt_updwn, cnt_datain,
                 busy, done, aborted, steps);
      end
    end else begin
      checks++;
      if (cnt_ld_en && cnt_en) begin
        fails++;
        $display("FAIL ld_en_excl got ld=1 en=1 want not both");
      end
      if (!busy) begin
        checks++;
        if (cnt_ld_en || cnt_en) begin
          fails++;
          $display("FAIL idle_strobes got ld=%b en=%b want 0 0", cnt_ld_en, cnt_en);
        end
      end else begin
        checks++;
        if (cnt_datain != cur_start || cnt_updwn != cur_dir) begin
          fails++;
          $display("FAIL fields got din=%0d ud=%b want din=%0d ud=%b",
                   cnt_datain, cnt_updwn, cur_start, cur_dir);
        end
      end
      if (done || aborted) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse got done=%b aborted=%b want none", done, aborted);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (done != !e.abrt || aborted != e.abrt) begin
            fails++;
            $display("FAIL pulse_kind got done=%b aborted=%b want aborted=%b",
                     done, aborted, e.abrt);
          end
          checks++;
          if (int'(steps) != e.steps) begin
            fails++;
            $display("FAIL steps got %0d want %0d", steps, e.steps);
          end
          checks++;
          if (cyc - e.acc != e.lat) begin
            fails++;
            $display("FAIL latency got %0d want %0d", cyc - e.acc, e.lat);
          end
          checks++;
          if (e.abrt ? !req_ready : busy) begin
            fails++;
            $display("FAIL post_state got rdy=%b busy=%b want abrt=%b", req_ready, busy, e.abrt);
          end
        end
      end else if (sb.size() != 0 && cyc - sb[0].acc > sb[0].lat) begin
        checks++;
        fails++;
        $display("FAIL pulse_timeout got no pulse want at latency %0d", sb[0].lat);
        void'(sb.pop_front());
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 4; i++) begin
      if (req_ready) break;
      @(posedge clk); #1;
    end
    if (!req_ready) begin
      $display("FAIL ready_wait got rdy=0 want 1");
      $fatal(1, "no ready");
    end
  endtask

  task automatic run_job(input logic [7:0] st, input logic [7:0] tg,
                         input logic d, input int ab_at);
    exp_t e;
    model(st, tg, d, ab_at, e);
    wait_ready();
    req_valid  = 1'b1;
    req_start  = st;
    req_target = tg;
    req_dir    = d;
    cur_start  = st;
    cur_dir    = d;
    @(posedge clk); #1;
    e.acc = cyc;
    sb.push_back(e);
    for (int k = 1; k <= e.lat + 1; k++) begin
      req_valid  = (k <= e.lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_start  = 8'($urandom);
      req_target = 8'($urandom);
      req_dir    = 1'($urandom);
      pause      = pz[k];
      abort      = (k == ab_at) ||
                   (k == e.lat + 1 && $urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    pause     = 1'b0;
    abort     = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic clear_pz();
    for (int i = 0; i < 1024; i++) pz[i] = 1'b0;
  endtask

  initial begin
    clear_pz();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_job(8'd10, 8'd15, 1'b1, 0);
    run_job(8'd2, 8'd254, 1'b0, 0);
    run_job(8'd77, 8'd77, 1'b1, 0);
    for (int k = 5; k <= 7; k++) pz[k] = 1'b1;
    run_job(8'd0, 8'd8, 1'b1, 0);
    clear_pz();
    pz[22] = 1'b1;
    run_job(8'd0, 8'd100, 1'b1, 22);
    clear_pz();

    wait_ready();
    req_valid  = 1'b1;
    req_start  = 8'd0;
    req_target = 8'd50;
    req_dir    = 1'b1;
    cur_start  = 8'd0;
    cur_dir    = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (steps == 8'd4) break;
      @(posedge clk); #1;
    end
    if (steps != 8'd4) begin
      $display("FAIL step4_wait got %0d want 4", steps);
      $fatal(1, "no step 4");
    end
    rst_n     = 1'b0;
    cur_start = 8'd0;
    cur_dir   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_job(8'd5, 8'd6, 1'b1, 0);

    for (int j = 0; j < 40; j++) begin
      logic [7:0] st;
      logic [7:0] tg;
      logic       d;
      int         ab;
      st = 8'($urandom);
      tg = (j % 5 == 0) ? st : 8'($urandom);
      d  = 1'($urandom);
      for (int i = 0; i < 1024; i++) pz[i] = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
      run_job(st, tg, d, ab);
    end

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, width of counter data, job fields and step count.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  job request valid.
REQ-005 req_ready  output  1  controller can accept a job.
REQ-006 req_start  input  WIDTH  value loaded into counter at job start.
REQ-007 req_target  input  WIDTH  value at which counting stops.
REQ-008 req_dir  input  1  1 = count up, 0 = count down.
REQ-009 pause  input  1  hold counting while high.
REQ-010 abort  input  1  cancel the active job.
REQ-011 cnt_ld_en  output  1  counter load enable.
REQ-012 cnt_updwn  output  1  counter direction: 1 up, 0 down.
REQ-013 cnt_en  output  1  counter count enable.
REQ-014 cnt_datain  output  WIDTH  counter load value.
REQ-015 cnt_dataout  input  WIDTH  registered counter value.
REQ-016 busy  output  1  job in LOAD or COUNT.
REQ-017 done  output  1  one-cycle pulse on job completion.
REQ-018 aborted  output  1  one-cycle pulse on job cancellation.
REQ-019 steps  output  WIDTH  number of cycles with cnt_en high in the current or last job.

Function
REQ-020 Counter contract: cnt_ld_en loads cnt_datain at the next edge and overrides cnt_en; cnt_en steps by 1 in direction cnt_updwn; value wraps modulo 2^WIDTH.
REQ-021 FSM states: IDLE, LOAD, COUNT, DONE.
REQ-022 req_ready is 1 only in IDLE; a job is accepted on an edge with req_valid && req_ready; start, target and dir are captured and steps is cleared; the next state is LOAD.
REQ-023 LOAD lasts exactly one cycle: cnt_ld_en=1, cnt_datain=captured start, cnt_en=0; the next state is COUNT.
REQ-024 COUNT: cnt_updwn=captured dir; cnt_en = (cnt_dataout != target) && !pause && !abort, driven combinationally.
REQ-025 Each cycle with cnt_en=1 increments steps by 1.
REQ-026 COUNT -> DONE when cnt_dataout == target, with cnt_en=0 in that cycle.
REQ-027 DONE lasts one cycle: done=1; the next state is IDLE.
REQ-028 Job latency from the accept edge to done high is steps+2 cycles.
REQ-029 Up job: steps = (target - start) mod 2^WIDTH. Down job: steps = (start - target) mod 2^WIDTH. Wrap through 255/0 is legal.
REQ-030 start == target: COUNT detects the match in its first cycle; steps=0; done rises 2 cycles after the accept edge.
REQ-031 pause: while high in COUNT, cnt_en=0 and steps holds; the state stays COUNT unless cnt_dataout matches target, in which case it moves to DONE; pause is ignored in IDLE, LOAD and DONE.
REQ-032 abort in LOAD or COUNT: outputs cnt_ld_en=0 and cnt_en=0 that cycle, pulses aborted next cycle, and returns to IDLE; done is not asserted; steps holds.
REQ-033 abort takes priority over pause and over the target match.
REQ-034 abort is ignored in IDLE and DONE.
REQ-035 req_valid outside IDLE has no effect; the job fields are sampled only at the accept edge.
REQ-036 cnt_ld_en and cnt_en are never high in the same cycle; both are 0 outside LOAD and COUNT.
REQ-037 cnt_datain = captured start in all states; cnt_updwn = captured dir in all states.

Reset
REQ-038 rst_n low asynchronously forces: state IDLE; req_ready=1; cnt_ld_en=0; cnt_en=0; cnt_updwn=0; cnt_datain=0; busy=0; done=0; aborted=0; steps=0; captured fields=0.
REQ-039 Reset mid-job discards the job with no done or aborted pulse; the first accept is possible on the first edge after rst_n rises.

Verification
REQ-040 Up job: start=10, target=15, dir=1 -> one LOAD cycle with datain=10, 5 cnt_en cycles, done 7 cycles after accept, steps=5.
REQ-041 Down wrap: start=2, target=254, dir=0 -> counter passes 1,0,255,254; steps=4; done pulses once.
REQ-042 Equal: start=target=77 -> steps=0, done 2 cycles after accept, cnt_en never high.
REQ-043 Pause: up job 0->8, pause high for 3 cycles after step 3 -> steps=8, done delayed by 3 cycles, no cnt_en during pause.
REQ-044 Abort: up job 0->100, abort at step 20 (pause also high) -> aborted pulses, done=0, steps=20, req_ready=1 next cycle.
REQ-045 Reset mid-COUNT: rst_n low at step 4 -> all outputs at reset values immediately; a new job 5->6 then completes with steps=1.
